rf_wb_queue: RTL and testbench

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

---
 rtl/rf_wb_queue.sv | 116 +++++++++++
 tb/tb_rf_wb_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_queue.sv
// Writeback queue: an in-order FIFO of {addr, data} results that drains one entry per cycle into the register file.
// Define RF_WB_QUEUE_FWD_EN to build the decode-stage forwarding lookup; without it the fwd_* outputs are tied to 0.
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_addr,
    input  logic [31:0]              in_data,
    output logic                     RegWrite,
    output logic [4:0]               wr_addr,
    output logic [31:0]              wr_data,
    input  logic [4:0]               rd_addr1,
    input  logic [4:0]               rd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [31:0]              fwd_data1,
    output logic [31:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic accept;
    logic store;
    logic pop;

    // While rst is low every handshake and write-enable output is forced off.
    assign in_ready = rst && (count_q < CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign store    = accept && (in_addr != 5'd0);
    assign pop      = rst && (count_q != '0);
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({store, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; count and pointers alone decide which slots are live, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (store) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // The head slot is presented every cycle the queue is non-empty and pops on the following edge.
    assign RegWrite = pop;
    assign wr_addr  = pop ? addr_mem[rd_ptr] : 5'd0;
    assign wr_data  = pop ? data_mem[rd_ptr] : 32'd0;

`ifdef RF_WB_QUEUE_FWD_EN
    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } fwd_t;

    // Scan head to tail so a younger match overrides an older one; the current offer is never looked at.
    function automatic fwd_t lookup(input logic [4:0] ra);
        fwd_t r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rst && (ra != 5'd0) && (CW'(i) < count_q) &&
                (addr_mem[rd_ptr + PW'(i)] == ra)) begin
                r.hit  = 1'b1;
                r.data = data_mem[rd_ptr + PW'(i)];
            end
        end
        return r;
    endfunction

    fwd_t fwd1;
    fwd_t fwd2;

    // NOTE: lookup results are fully assigned on every pass, so no latch can be inferred.
    always_comb begin
        fwd1 = lookup(rd_addr1);
        fwd2 = lookup(rd_addr2);
    end

    assign fwd_hit1  = fwd1.hit;
    assign fwd_data1 = fwd1.data;
    assign fwd_hit2  = fwd2.hit;
    assign fwd_data2 = fwd2.data;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1, rd_addr2};

    assign fwd_hit1  = 1'b0;
    assign fwd_data1 = 32'd0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed vector table, a pointer-wrap sequence, and a random run against a queue model.
module tb_rf_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_addr;
    logic [31:0]   in_data;
    logic          RegWrite;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [4:0]    rd_addr1;
    logic [4:0]    rd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [31:0]   fwd_data1;
    logic [31:0]   fwd_data2;
    logic [CW-1:0] count;

    rf_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .RegWrite  (RegWrite),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag,
                               input logic e_ready, input logic e_we,
                               input logic [4:0] e_wa, input logic [31:0] e_wd,
                               input logic [CW-1:0] e_cnt,
                               input logic e_h1, input logic [31:0] e_d1,
                               input logic e_h2, input logic [31:0] e_d2);
        check({tag, ".in_ready"},  32'(in_ready),  32'(e_ready));
        check({tag, ".RegWrite"},  32'(RegWrite),  32'(e_we));
        check({tag, ".wr_addr"},   32'(wr_addr),   32'(e_wa));
        check({tag, ".wr_data"},   wr_data,        e_wd);
        check({tag, ".count"},     32'(count),     32'(e_cnt));
        check({tag, ".fwd_hit1"},  32'(fwd_hit1),  32'(e_h1));
        check({tag, ".fwd_data1"}, fwd_data1,      e_d1);
        check({tag, ".fwd_hit2"},  32'(fwd_hit2),  32'(e_h2));
        check({tag, ".fwd_data2"}, fwd_data2,      e_d2);
    endtask

    // Directed vectors: inputs for one cycle and the outputs expected during that cycle.
    typedef struct {
        logic          r;
        logic          v;
        logic [4:0]    a;
        logic [31:0]   d;
        logic [4:0]    r1;
        logic [4:0]    r2;
        logic          e_ready;
        logic          e_we;
        logic [4:0]    e_wa;
        logic [31:0]   e_wd;
        logic [CW-1:0] e_cnt;
        logic          e_h1;
        logic [31:0]   e_d1;
        logic          e_h2;
        logic [31:0]   e_d2;
    } vec_t;

    function automatic vec_t mk(input int r, v, a, d, r1, r2,
                                input int er, ewe, ewa, ewd, ec,
                                input int eh1, ed1, eh2, ed2);
        vec_t t;
        t.r = 1'(r);   t.v = 1'(v);   t.a = 5'(a);   t.d = 32'(d);
        t.r1 = 5'(r1); t.r2 = 5'(r2);
        t.e_ready = 1'(er); t.e_we = 1'(ewe); t.e_wa = 5'(ewa); t.e_wd = 32'(ewd);
        t.e_cnt = CW'(ec);
        t.e_h1 = 1'(eh1); t.e_d1 = 32'(ed1); t.e_h2 = 1'(eh2); t.e_d2 = 32'(ed2);
        return t;
    endfunction

    // Reference model: the queue contents as a list of pending writes, oldest first.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t model_q[$];

    task automatic model_edge(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d);
        if (!r) begin
            model_q.delete();
        end else begin
            logic acc;
            acc = v && (model_q.size() < DEPTH);
            if (model_q.size() != 0) void'(model_q.pop_front());
            if (acc && a != 5'd0) model_q.push_back('{addr: a, data: d});
        end
    endtask

    function automatic void model_fwd(input logic r, input logic [4:0] ra,
                                      output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = 32'd0;
        if (r && ra != 5'd0) begin
            for (int k = model_q.size() - 1; k >= 0; k--) begin
                if (model_q[k].addr == ra) begin
                    hit  = 1'b1;
                    data = model_q[k].data;
                    break;
                end
            end
        end
`ifndef RF_WB_QUEUE_FWD_EN
        hit  = 1'b0;
        data = 32'd0;
`endif
    endfunction

    task automatic drive(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2);
        rst = r; in_valid = v; in_addr = a; in_data = d; rd_addr1 = r1; rd_addr2 = r2;
    endtask

    vec_t tbl[$];
    logic [4:0]  got_a[$];
    logic [31:0] got_d[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        //      r v a  d        r1 r2  rdy we wa wd      cnt h1 d1     h2 d2
        tbl.push_back(mk(0, 1, 4, 'h44,   0, 0,  0, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 5, 'hAA,   0, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,  1, 1, 5, 'hAA,   1, 0, 0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 1, 'h101,  0, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 2, 'h102,  0, 0,  1, 1, 1, 'h101,  1, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 3, 'h103,  0, 0,  1, 1, 2, 'h102,  1, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 4, 'h104,  0, 0,  1, 1, 3, 'h103,  1, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 5, 'h105,  0, 0,  1, 1, 4, 'h104,  1, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 6, 'h106,  0, 0,  1, 1, 5, 'h105,  1, 0, 0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,  1, 1, 6, 'h106,  1, 0, 0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 0, 'hDEAD, 0, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 7, 'h11,   0, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 7, 'h22,   7, 7,  1, 1, 7, 'h11,   1, 1, 'h11,  1, 'h11));
        tbl.push_back(mk(1, 0, 0, 0,      7, 0,  1, 1, 7, 'h22,   1, 1, 'h22,  0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      7, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 1, 9, 'h99,   9, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 1, 3, 'h33,   9, 9,  0, 0, 0, 0,      1, 0, 0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      9, 3,  1, 0, 0, 0,      0, 0, 0,     0, 0));
        tbl.push_back(mk(1, 0, 0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 0,     0, 0));

        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            logic        eh1, eh2;
            logic [31:0] ed1, ed2;
            eh1 = tbl[i].e_h1; ed1 = tbl[i].e_d1; eh2 = tbl[i].e_h2; ed2 = tbl[i].e_d2;
`ifndef RF_WB_QUEUE_FWD_EN
            eh1 = 1'b0; ed1 = 32'd0; eh2 = 1'b0; ed2 = 32'd0;
`endif
            drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].r1, tbl[i].r2);
            #1;
            compare_all($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_we, tbl[i].e_wa,
                        tbl[i].e_wd, tbl[i].e_cnt, eh1, ed1, eh2, ed2);
            @(posedge clk);
            #1;
        end

        // Back-to-back offers for many pointer laps: nothing lost, duplicated or reordered.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b1, 5'(10 + k), 32'(3 * (10 + k)), 5'd0, 5'd0);
            #1;
            check($sformatf("wrap%0d.in_ready", k), 32'(in_ready), 32'd1);
            check($sformatf("wrap%0d.count_le1", k), 32'(count <= CW'(1)), 32'd1);
            if (RegWrite) begin
                got_a.push_back(wr_addr);
                got_d.push_back(wr_data);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (RegWrite) begin
                got_a.push_back(wr_addr);
                got_d.push_back(wr_data);
            end
            @(posedge clk);
            #1;
        end
        check("wrap.write_count", 32'(got_a.size()), 32'd12);
        for (int k = 0; k < 12; k++) begin
            logic [4:0]  ga;
            logic [31:0] gd;
            ga = (k < got_a.size()) ? got_a[k] : 5'd0;
            gd = (k < got_d.size()) ? got_d[k] : 32'd0;
            check($sformatf("wrap%0d.wr_addr", k), 32'(ga), 32'(10 + k));
            check($sformatf("wrap%0d.wr_data", k), gd, 32'(3 * (10 + k)));
        end

        // Random traffic against the model, with occasional resets.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            logic        r, v, eh1, eh2, e_we;
            logic [4:0]  a, r1, r2, e_wa;
            logic [31:0] d, ed1, ed2, e_wd;
            r  = ($urandom_range(0, 39) != 0);
            v  = ($urandom_range(0, 3) != 0);
            a  = 5'($urandom_range(0, 7));
            d  = $urandom;
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            drive(r, v, a, d, r1, r2);
            #1;
            e_we = r && (model_q.size() != 0);
            e_wa = e_we ? model_q[0].addr : 5'd0;
            e_wd = e_we ? model_q[0].data : 32'd0;
            model_fwd(r, r1, eh1, ed1);
            model_fwd(r, r2, eh2, ed2);
            compare_all($sformatf("rnd%0d", c), r && (model_q.size() < DEPTH), e_we, e_wa, e_wd,
                        CW'(model_q.size()), eh1, ed1, eh2, ed2);
            @(posedge clk);
            model_edge(r, v, a, d);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
